// File: rtl/fp_divider_seq.sv
// Sequential IEEE-754 single-precision divider: restoring radix-2 mantissa
// division, one quotient bit per cycle, FTZ, round-to-nearest-even.
module fp_divider_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  state_t             state;
  logic               sign;
  logic [23:0]        mb;
  logic [24:0]        rem;
  logic [25:0]        q;
  logic [4:0]         cnt;
  logic signed [9:0]  exp_d;

  // Handshake: a transfer happens on an edge where valid && ready are both
  // high; out_valid is held with stable data until out_ready accepts it.
  assign in_ready = (state == IDLE);

  // Operand classification on the live inputs (only used on the accept edge)
  logic [7:0] ea, eb;
  logic       s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  assign ea     = a[30:23];
  assign eb     = b[30:23];
  assign s      = a[31] ^ b[31];
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);

  logic        sp_hit, sp_dbz;
  logic [31:0] sp_res;
  always_comb begin
    sp_hit = 1'b1;
    sp_dbz = 1'b0;
    sp_res = {s, 31'd0};
    if (a_nan || b_nan)                             sp_res = QNAN;
    else if ((a_zero && b_zero) || (a_inf && b_inf)) sp_res = QNAN;
    else if (a_inf)                                 sp_res = {s, 8'hFF, 23'd0};
    else if (b_inf)                                 sp_res = {s, 31'd0};
    else if (a_zero)                                sp_res = {s, 31'd0};
    else if (b_zero) begin
      sp_res = {s, 8'hFF, 23'd0};
      sp_dbz = 1'b1;
    end else
      sp_hit = 1'b0;
  end

  // One restoring step; the partial remainder stays below 2*mb so 25 bits suffice
  logic [25:0] diff;
  logic        qbit;
  logic [24:0] rem_sub, rem_next;
  assign diff     = {1'b0, rem} - {2'b00, mb};
  assign qbit     = ~diff[25];
  assign rem_sub  = qbit ? diff[24:0] : rem;
  assign rem_next = {rem_sub[23:0], 1'b0};

  // Normalise, round and pack from the finished quotient
  logic [23:0]       mant;
  logic              guard, sticky, rnd;
  logic [24:0]       mant_r;
  logic signed [9:0] exp_n, exp_f;
  logic              ovf, unf;
  logic [31:0]       norm_res;
  always_comb begin
    mant     = q[25] ? q[25:2] : q[24:1];
    guard    = q[25] ? q[1] : q[0];
    sticky   = (q[25] & q[0]) | (rem != 25'd0);
    exp_n    = q[25] ? exp_d + 10'sd1 : exp_d;
    rnd      = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {24'd0, rnd};
    exp_f    = mant_r[24] ? exp_n + 10'sd1 : exp_n;
    ovf      = (exp_f >= 10'sd255);
    unf      = (exp_f <= 10'sd0);
    norm_res = {sign, exp_f[7:0], mant_r[22:0]};
    if (ovf)      norm_res = {sign, 8'hFF, 23'd0};
    else if (unf) norm_res = {sign, 31'd0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sign        <= 1'b0;
      mb          <= 24'd0;
      rem         <= 25'd0;
      q           <= 26'd0;
      cnt         <= 5'd0;
      exp_d       <= 10'sd0;
      out_valid   <= 1'b0;
      result      <= 32'd0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign <= s;
          if (sp_hit) begin
            result      <= sp_res;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= sp_dbz;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            mb    <= {1'b1, b[22:0]};
            rem   <= {2'b01, a[22:0]};
            q     <= 26'd0;
            cnt   <= 5'd25;
            exp_d <= $signed({2'b00, ea} - {2'b00, eb} + 10'd126);
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          q   <= {q[24:0], qbit};
          rem <= rem_next;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= NORM;
        end
        NORM: begin
          result      <= norm_res;
          overflow    <= ovf;
          underflow   <= ~ovf & unf;
          div_by_zero <= 1'b0;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider_seq.sv
// Directed bench for fp_divider_seq: results, flags, latency, backpressure
// and reset abort, checked against hand-computed constants.
module tb_fp_divider_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow, underflow, div_by_zero;

  int tests = 0;
  int fails = 0;

  fp_divider_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .underflow(underflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Issue one operation, wait for out_valid, check result, flags {ovf,unf,dbz}
  // and accept-to-valid latency; optionally complete the output handshake.
  task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic [31:0] exp_res, input logic [2:0] exp_flags,
                        input int exp_lat, input bit release_out);
    int lat;
    @(negedge clk);
    check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    a = op_a; b = op_b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_flg"}, {29'd0, overflow, underflow, div_by_zero}, {29'd0, exp_flags});
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_ovl"}, {31'd0, out_valid}, 32'd0);
    end
  endtask

  logic [31:0] held;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ovl", {31'd0, out_valid}, 32'd0);
    check("rst_res", result, 32'd0);
    check("rst_flg", {29'd0, overflow, underflow, div_by_zero}, 32'd0);
    check("rst_rdy", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    run_op("six_div_three", 32'h40C00000, 32'h40400000, 32'h40000000, 3'b000, 27, 1);
    run_op("one_div_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000, 27, 1);
    run_op("neg_7p5_2p5",   32'hC0F00000, 32'h40200000, 32'hC0400000, 3'b000, 27, 1);
    run_op("two_div_one",   32'h40000000, 32'h3F800000, 32'h40000000, 3'b000, 27, 1);
    run_op("one_div_zero",  32'h3F800000, 32'h00000000, 32'h7F800000, 3'b001, 0, 1);
    run_op("negx_div_zero", 32'hC0000000, 32'h00000000, 32'hFF800000, 3'b001, 0, 1);
    run_op("zero_div_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 3'b000, 0, 1);
    run_op("nan_div_one",   32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b000, 0, 1);
    run_op("inf_div_inf",   32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b000, 0, 1);
    run_op("inf_div_two",   32'h7F800000, 32'h40000000, 32'h7F800000, 3'b000, 0, 1);
    run_op("two_div_ninf",  32'h40000000, 32'hFF800000, 32'h80000000, 3'b000, 0, 1);
    run_op("nzero_div_one", 32'h80000000, 32'h3F800000, 32'h80000000, 3'b000, 0, 1);
    run_op("denorm_flush",  32'h00400000, 32'h3F800000, 32'h00000000, 3'b000, 0, 1);
    run_op("overflow",      32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b100, 27, 1);
    run_op("underflow",     32'h00800000, 32'h40000000, 32'h00000000, 3'b010, 27, 1);

    // Backpressure: hold DONE, toggle in_valid with fresh operands
    run_op("bp", 32'h40C00000, 32'h40400000, 32'h40000000, 3'b000, 27, 0);
    held = result;
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      a = 32'h3F800000; b = 32'h00000000;
      @(posedge clk);
      @(negedge clk);
      check("bp_res", result, 32'h40000000);
      check("bp_ovl", {31'd0, out_valid}, 32'd1);
      check("bp_rdy", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    check("bp_held", result, held);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_rel_ovl", {31'd0, out_valid}, 32'd0);
    check("bp_rel_rdy", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of DIVIDE
    a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ovl", {31'd0, out_valid}, 32'd0);
    check("mid_rst_res", result, 32'd0);
    check("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 32'h40C00000, 32'h40400000, 32'h40000000, 3'b000, 27, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
